// File: rtl/fpu_pkg.sv
// ============================================================================
// Module  : fpu_pkg
// Brief   : Shared widths and IEEE exception flag bit positions for the FPU.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fpu_pkg;

   localparam int SP_WIDTH   = 32;
   localparam int FLAG_WIDTH = 5;

   // Flag vector order is {invalid, divzero, overflow, underflow, inexact}.
   localparam int FLAG_INVALID   = 4;
   localparam int FLAG_DIVZERO   = 3;
   localparam int FLAG_OVERFLOW  = 2;
   localparam int FLAG_UNDERFLOW = 1;
   localparam int FLAG_INEXACT   = 0;

   typedef logic [FLAG_WIDTH-1:0] fpu_flags_t;

endpackage

`default_nettype wire

// File: rtl/fpu_wrap_ptr.sv
// ============================================================================
// Module  : fpu_wrap_ptr
// Brief   : Resettable queue pointer; increments on enable and wraps at Depth.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpu_wrap_ptr #(
   parameter int Depth = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     en_i,
   output logic [$clog2(Depth)-1:0] ptr_o
);

   localparam int PW = $clog2(Depth);

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;

   // Depth is a power of two, so natural overflow performs the wrap.
   always_comb begin
      ptr_d = ptr_q;
      if (en_i) begin
         ptr_d = ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/fpu_result_queue.sv
// ============================================================================
// Module  : fpu_result_queue
// Brief   : Circular result queue after Add_Sub with sticky exception status.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fpu_result_queue
   import fpu_pkg::*;
#(
   parameter int DataSize = SP_WIDTH,
   parameter int FlagSize = FLAG_WIDTH,
   parameter int Depth    = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     InValid,
   output logic                     InReady,
   input  logic [DataSize-1:0]      InData,
   input  logic [FlagSize-1:0]      InFlags,
   output logic                     OutValid,
   input  logic                     OutReady,
   output logic [DataSize-1:0]      OutData,
   output logic [FlagSize-1:0]      OutFlags,
   output logic [$clog2(Depth):0]   Count,
   input  logic                     ClearFlags,
   output logic [FlagSize-1:0]      StickyFlags
);

   localparam int PW = $clog2(Depth);
   localparam int CW = PW + 1;

   logic [DataSize-1:0] data_q  [Depth];
   logic [FlagSize-1:0] flags_q [Depth];
   logic [CW-1:0]       count_q;
   logic [CW-1:0]       count_d;
   logic [FlagSize-1:0] sticky_q;
   logic [FlagSize-1:0] sticky_d;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic                push;
   logic                pop;

   // Handshake outputs depend on registered count only, never on same-cycle inputs.
   assign InReady  = (count_q < CW'(Depth));
   assign OutValid = (count_q != '0);
   assign push     = InValid && InReady;
   assign pop      = OutValid && OutReady;

   fpu_wrap_ptr #(.Depth(Depth)) u_wr_ptr (
      .clk_i (CLK),
      .rst_i (RST),
      .en_i  (push),
      .ptr_o (wr_ptr)
   );

   fpu_wrap_ptr #(.Depth(Depth)) u_rd_ptr (
      .clk_i (CLK),
      .rst_i (RST),
      .en_i  (pop),
      .ptr_o (rd_ptr)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < Depth; i++) begin
            data_q[i]  <= '0;
            flags_q[i] <= '0;
         end
      end else if (push) begin
         data_q[wr_ptr]  <= InData;
         flags_q[wr_ptr] <= InFlags;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Clear wins over the old status, but a same-cycle pop still lands.
   always_comb begin
      sticky_d = ClearFlags ? '0 : sticky_q;
      if (pop) begin
         sticky_d = sticky_d | flags_q[rd_ptr];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         count_q  <= '0;
         sticky_q <= '0;
      end else begin
         count_q  <= count_d;
         sticky_q <= sticky_d;
      end
   end

   assign OutData     = data_q[rd_ptr];
   assign OutFlags    = flags_q[rd_ptr];
   assign Count       = count_q;
   assign StickyFlags = sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_result_queue.sv
// ============================================================================
// Module  : tb_fpu_result_queue
// Brief   : Scoreboard bench for fpu_result_queue with directed and random traffic.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fpu_result_queue;

   logic        CLK;
   logic        RST;
   logic        InValid;
   logic        InReady;
   logic [31:0] InData;
   logic [4:0]  InFlags;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] OutData;
   logic [4:0]  OutFlags;
   logic [2:0]  Count;
   logic        ClearFlags;
   logic [4:0]  StickyFlags;

   int checks   = 0;
   int failures = 0;

   logic [36:0] sb_q[$];
   int          m_count  = 0;
   logic [4:0]  m_sticky = '0;

   fpu_result_queue #(.DataSize(32), .FlagSize(5), .Depth(4)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .InValid     (InValid),
      .InReady     (InReady),
      .InData      (InData),
      .InFlags     (InFlags),
      .OutValid    (OutValid),
      .OutReady    (OutReady),
      .OutData     (OutData),
      .OutFlags    (OutFlags),
      .Count       (Count),
      .ClearFlags  (ClearFlags),
      .StickyFlags (StickyFlags)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   // Monitor: model of count/sticky, pops compared against scoreboard order.
   always @(negedge CLK) begin
      logic [36:0] exp;
      logic        m_pop;
      logic        m_push;
      if (RST) begin
         sb_q.delete();
         m_count  = 0;
         m_sticky = '0;
      end else begin
         check("count", 64'(Count), 64'(m_count));
         check("in_ready", 64'(InReady), 64'(m_count < 4));
         check("out_valid", 64'(OutValid), 64'(m_count > 0));
         check("sticky", 64'(StickyFlags), 64'(m_sticky));
         m_pop  = (m_count > 0) && OutReady;
         m_push = (m_count < 4) && InValid;
         exp    = '0;
         if (m_pop) begin
            if (sb_q.size() == 0) begin
               check("sb_underflow", 64'(sb_q.size()), 64'(1));
            end else begin
               exp = sb_q.pop_front();
               check("out_data", 64'(OutData), 64'(exp[36:5]));
               check("out_flags", 64'(OutFlags), 64'(exp[4:0]));
            end
         end
         m_sticky = (ClearFlags ? 5'b0 : m_sticky) | (m_pop ? exp[4:0] : 5'b0);
         if (m_push) sb_q.push_back({InData, InFlags});
         m_count = m_count + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
      end
   end

   // Handshake outputs may only move at a posedge (or on async reset).
   always @(InReady or OutValid) begin
      if (!RST && $time > 0) check("hs_edge_aligned", 64'($time % 10), 64'(5));
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; InValid = 1'b0; OutReady = 1'b0; ClearFlags = 1'b0;
      InData = 'x; InFlags = '0;
      repeat (2) cyc();
      #2 RST = 1'b0;
      check("rst_out_valid", 64'(OutValid), 64'(0));
      check("rst_in_ready", 64'(InReady), 64'(1));
      check("rst_count", 64'(Count), 64'(0));
      check("rst_out_data", 64'(OutData), 64'(0));
      check("rst_out_flags", 64'(OutFlags), 64'(0));
      check("rst_sticky", 64'(StickyFlags), 64'(0));
      cyc();

      // Single pass
      InValid = 1'b1; InData = 32'h3F80_0000; InFlags = 5'b00001;
      cyc();
      InValid = 1'b0; InData = 'x;
      check("t1_valid", 64'(OutValid), 64'(1));
      check("t1_data", 64'(OutData), 64'h3F80_0000);
      check("t1_flags", 64'(OutFlags), 64'(5'b00001));
      check("t1_count", 64'(Count), 64'(1));
      OutReady = 1'b1;
      cyc();
      OutReady = 1'b0;
      check("t1_count_after", 64'(Count), 64'(0));
      check("t1_sticky", 64'(StickyFlags), 64'(5'b00001));

      // Fill and hold
      ClearFlags = 1'b1; cyc(); ClearFlags = 1'b0;
      for (int i = 0; i < 4; i++) begin
         InValid = 1'b1;
         case (i)
            0: InData = 32'h4000_0000;
            1: InData = 32'h4040_0000;
            2: InData = 32'h4080_0000;
            default: InData = 32'h40A0_0000;
         endcase
         InFlags = '0;
         cyc();
      end
      check("t2_full_count", 64'(Count), 64'(4));
      check("t2_full_ready", 64'(InReady), 64'(0));
      check("t2_head", 64'(OutData), 64'h4000_0000);
      InData = 32'h40C0_0000;
      repeat (3) cyc();
      check("t2_held_count", 64'(Count), 64'(4));
      OutReady = 1'b1; cyc(); OutReady = 1'b0;
      check("t2_ready_rise", 64'(InReady), 64'(1));
      check("t2_count3", 64'(Count), 64'(3));
      cyc();
      InValid = 1'b0; InData = 'x;
      check("t2_refill", 64'(Count), 64'(4));
      OutReady = 1'b1; repeat (5) cyc(); OutReady = 1'b0;
      check("t2_drained", 64'(Count), 64'(0));

      // Streaming
      InValid = 1'b1; OutReady = 1'b1;
      for (int i = 0; i < 10; i++) begin
         InData = 32'(i + 1); InFlags = '0;
         cyc();
         check("t3_stream_count", 64'(Count), 64'(1));
      end
      InValid = 1'b0; InData = 'x;
      cyc();
      OutReady = 1'b0;
      check("t3_end_count", 64'(Count), 64'(0));

      // Sticky flags
      ClearFlags = 1'b1; cyc(); ClearFlags = 1'b0;
      InValid = 1'b1;
      InData = 32'h1; InFlags = 5'b00100; cyc();
      InData = 32'h2; InFlags = 5'b00001; cyc();
      InData = 32'h3; InFlags = 5'b10000; cyc();
      InValid = 1'b0; InData = 'x; InFlags = '0;
      OutReady = 1'b1; repeat (2) cyc(); OutReady = 1'b0;
      check("t4_sticky_or", 64'(StickyFlags), 64'(5'b00101));
      OutReady = 1'b1; ClearFlags = 1'b1; cyc(); OutReady = 1'b0; ClearFlags = 1'b0;
      check("t4_clear_pop", 64'(StickyFlags), 64'(5'b10000));
      ClearFlags = 1'b1; cyc(); ClearFlags = 1'b0;
      check("t4_clear", 64'(StickyFlags), 64'(0));

      // Async reset with Count=3
      InValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         InData = 32'hA0 + 32'(i); InFlags = 5'b00010; cyc();
      end
      InValid = 1'b0; InData = 'x; InFlags = '0;
      OutReady = 1'b1; cyc(); OutReady = 1'b0;
      check("t5_pre_count", 64'(Count), 64'(3));
      check("t5_pre_sticky", 64'(StickyFlags), 64'(5'b00010));
      #2 RST = 1'b1;
      #1;
      check("t5_valid", 64'(OutValid), 64'(0));
      check("t5_count", 64'(Count), 64'(0));
      check("t5_ready", 64'(InReady), 64'(1));
      check("t5_sticky", 64'(StickyFlags), 64'(0));
      #3 RST = 1'b0;
      cyc();
      InValid = 1'b1; InData = 32'h1234_5678; InFlags = 5'b01000;
      cyc();
      InValid = 1'b0; InData = 'x; InFlags = '0;
      check("t5_post_valid", 64'(OutValid), 64'(1));
      check("t5_post_data", 64'(OutData), 64'h1234_5678);
      OutReady = 1'b1; cyc(); OutReady = 1'b0;

      // Random handshakes
      for (int i = 0; i < 1000; i++) begin
         InValid    = 1'($urandom_range(0, 1));
         InData     = $urandom;
         InFlags    = 5'($urandom_range(0, 31));
         OutReady   = 1'($urandom_range(0, 1));
         ClearFlags = ($urandom_range(0, 15) == 0);
         cyc();
      end
      InValid = 1'b0; ClearFlags = 1'b0; OutReady = 1'b1;
      repeat (6) cyc();
      OutReady = 1'b0;
      cyc();
      check("final_count", 64'(Count), 64'(0));
      check("final_sb_empty", 64'(sb_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
